// File: rtl/cl_encode.sv
// Run-length encoder of a DEFLATE code-length sequence into CL symbols 0-18
// with extra bits, plus a 19-entry CL-symbol frequency histogram.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            pulse: clear histogram/count, re-arm after a header
//   len_valid/ready  code-length input handshake (len_data 0-15, len_last)
//   out_valid/ready  CL symbol output handshake (registered outputs)
//   out_sym          CL symbol 0-18
//   out_extra        extra-bits value, out_extra_nbits its width (0/2/3/7)
//   out_last         final symbol of the header
//   done             one-cycle pulse after the out_last handshake
//   sym_count        symbols emitted since start
//   freq_addr/data   combinational histogram read, addr >= 19 reads 0
module cl_encode #(
  parameter int MAX_RUN = 320,
  parameter int FREQ_W  = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              len_valid,
  output logic              len_ready,
  input  logic [3:0]        len_data,
  input  logic              len_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_sym,
  output logic [6:0]        out_extra,
  output logic [2:0]        out_extra_nbits,
  output logic              out_last,
  output logic              done,
  output logic [8:0]        sym_count,
  input  logic [4:0]        freq_addr,
  output logic [FREQ_W-1:0] freq_data
);

  localparam int RW = $clog2(MAX_RUN + 1);
  localparam int CAP18 = (MAX_RUN >= 138) ? 138 : MAX_RUN;

  localparam logic [RW-1:0] C1   = RW'(1);
  localparam logic [RW-1:0] C3   = RW'(3);
  localparam logic [RW-1:0] C6   = RW'(6);
  localparam logic [RW-1:0] C11  = RW'(11);
  localparam logic [RW-1:0] C138 = RW'(CAP18);
  localparam logic [RW-1:0] CMAX = RW'(MAX_RUN);

  typedef enum logic [1:0] {
    ACCUM,
    FLUSH,
    DONE
  } state_t;

  state_t state, state_n;

  logic [3:0]    cur_len;
  logic [RW-1:0] run_cnt;
  logic          run_active;
  logic          lit_sent;
  logic          final_run;
  logic          pend_valid;
  logic [3:0]    pend_len;
  logic          pend_last;

  logic [FREQ_W-1:0] freq [19];

  logic          len_hs;
  logic          out_hs;
  logic          can_load;
  logic          same;

  logic [4:0]    sym_n;
  logic [6:0]    ext_n;
  logic [2:0]    nb_n;
  logic [RW-1:0] take;

  assign len_ready = (state == ACCUM);
  assign len_hs    = len_valid && len_ready;
  assign out_hs    = out_valid && out_ready;
  assign can_load  = !out_valid || out_ready;

  // A full counter makes an equal length behave like a new length.
  assign same = run_active && (len_data == cur_len) && (run_cnt != CMAX);

  assign freq_data = (freq_addr < 5'd19) ? freq[freq_addr] : '0;

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ACCUM: begin
        if (len_hs && ((run_active && !same) || len_last))
          state_n = FLUSH;
      end
      FLUSH: begin
        if (can_load && run_cnt == '0) begin
          if (pend_valid) state_n = pend_last ? FLUSH : ACCUM;
          else            state_n = DONE;
        end
      end
      DONE: begin
        if (start) state_n = ACCUM;
      end
      default: state_n = ACCUM;
    endcase
  end

  // Next symbol for the remaining run; take is how much of it is consumed.
  always_comb begin
    sym_n = 5'd0;
    ext_n = 7'd0;
    nb_n  = 3'd0;
    take  = C1;
    if (cur_len == 4'd0) begin
      if (run_cnt >= C11) begin
        sym_n = 5'd18;
        take  = (run_cnt > C138) ? C138 : run_cnt;
        ext_n = 7'(take - C11);
        nb_n  = 3'd7;
      end else if (run_cnt >= C3) begin
        sym_n = 5'd17;
        take  = run_cnt;
        ext_n = 7'(run_cnt - C3);
        nb_n  = 3'd3;
      end
    end else if (lit_sent && run_cnt >= C3) begin
      sym_n = 5'd16;
      take  = (run_cnt > C6) ? C6 : run_cnt;
      ext_n = 7'(take - C3);
      nb_n  = 3'd2;
    end else begin
      sym_n = {1'b0, cur_len};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_len         <= '0;
      run_cnt         <= '0;
      run_active      <= 1'b0;
      lit_sent        <= 1'b0;
      final_run       <= 1'b0;
      pend_valid      <= 1'b0;
      pend_len        <= '0;
      pend_last       <= 1'b0;
      out_valid       <= 1'b0;
      out_sym         <= '0;
      out_extra       <= '0;
      out_extra_nbits <= '0;
      out_last        <= 1'b0;
      done            <= 1'b0;
      sym_count       <= '0;
      for (int i = 0; i < 19; i++) freq[i] <= '0;
    end else begin
      done <= (state == FLUSH) && (state_n == DONE);

      if (start && state != FLUSH) begin
        sym_count <= '0;
        for (int i = 0; i < 19; i++) freq[i] <= '0;
      end else if (out_hs) begin
        sym_count <= sym_count + 9'd1;
        if (freq[out_sym] != '1)
          freq[out_sym] <= freq[out_sym] + 1'b1;
      end

      unique case (state)
        ACCUM: begin
          if (len_hs) begin
            if (!run_active) begin
              cur_len    <= len_data;
              run_cnt    <= C1;
              run_active <= 1'b1;
              lit_sent   <= 1'b0;
              final_run  <= len_last;
            end else if (same) begin
              run_cnt   <= run_cnt + C1;
              final_run <= len_last;
            end else begin
              pend_valid <= 1'b1;
              pend_len   <= len_data;
              pend_last  <= len_last;
            end
          end
        end
        FLUSH: begin
          if (can_load) begin
            if (run_cnt != '0) begin
              out_valid       <= 1'b1;
              out_sym         <= sym_n;
              out_extra       <= ext_n;
              out_extra_nbits <= nb_n;
              out_last        <= final_run && (run_cnt == take);
              run_cnt         <= run_cnt - take;
              lit_sent        <= 1'b1;
            end else begin
              out_valid       <= 1'b0;
              out_sym         <= '0;
              out_extra       <= '0;
              out_extra_nbits <= '0;
              out_last        <= 1'b0;
              if (pend_valid) begin
                cur_len    <= pend_len;
                run_cnt    <= C1;
                lit_sent   <= 1'b0;
                final_run  <= pend_last;
                pend_valid <= 1'b0;
                pend_last  <= 1'b0;
              end else begin
                run_active <= 1'b0;
                final_run  <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          if (start) begin
            run_active <= 1'b0;
            final_run  <= 1'b0;
            pend_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/cl_encode.md
Name: cl_encode

Overview:
- Encoder counterpart of cl_decode, used on the dynamic-Huffman header path of the compressor.
- Takes the concatenated literal/length and distance code-length sequence (HLIT+HDIST entries), one length per handshake.
- Run-length encodes it into DEFLATE code-length (CL) symbols 0-18, with their extra bits.
- Keeps a 19-entry CL-symbol frequency histogram that the downstream CL Huffman tree builder reads.

Parameters:
- MAX_RUN, 320, maximum run length the run counter holds. Counter width is clog2(MAX_RUN+1).
- FREQ_W, 9, width of each histogram counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse: clears histogram and counters, arms the block for a new header
- len_valid  in  1  code length valid
- len_ready  out  1  block accepts the length this cycle
- len_data  in  4  code length 0-15
- len_last  in  1  final length of the sequence
- out_valid  out  1  CL symbol valid
- out_ready  in  1  downstream accepts
- out_sym  out  5  CL symbol 0-18
- out_extra  out  7  extra-bits value
- out_extra_nbits  out  3  extra-bit count: 0, 2, 3 or 7
- out_last  out  1  final CL symbol of the header
- done  out  1  one-cycle pulse after out_last handshake
- sym_count  out  9  CL symbols emitted since start
- freq_addr  in  5  histogram read address 0-18
- freq_data  out  FREQ_W  combinational histogram read; addr >= 19 returns 0

Behaviour:
- Reset (sync, active-high):
  - All outputs 0 except len_ready=1. The block also leaves reset armed.
  - Histogram, sym_count, run state cleared. State is ACCUM with no active run.
  - Reset mid-flush abandons the run; no further symbols are output.
- States:
  - ACCUM: len_ready=1.
    - Accepted length equal to cur_len with an active run: run_cnt += 1.
    - No active run: cur_len=len_data, run_cnt=1.
    - Different length with an active run: latch pending_len / pending_last, go FLUSH.
    - Accepted len_last with no pending entry: go FLUSH, mark final.
  - FLUSH: len_ready=0. Emits one symbol per out handshake until rem=0. Then:
    - With a pending entry: start a new run with pending_len, run_cnt=1.
      - If pending_last: FLUSH again, marked final.
      - Otherwise: back to ACCUM.
    - Final run: go DONE.
  - DONE: len_ready=0, out_valid=0. done pulses once on entry. start goes to ACCUM with histogram and sym_count cleared.
  - start in ACCUM with no run: clears only. start in FLUSH: ignored.
- Emission rules (rem = remaining run; one symbol per cycle; evaluated at each handshake):
  - Zero run:
    - rem >= 11: sym 18, n=min(rem,138), extra=n-11, nbits 7.
    - 3 <= rem <= 10: sym 17, extra=rem-3, nbits 3.
    - rem 1-2: sym 0, nbits 0, rem -= 1.
  - Nonzero run:
    - First symbol is the literal cur_len, nbits 0.
    - Then rem >= 3: sym 16, n=min(rem,6), extra=n-3, nbits 2.
    - Then rem 1-2: literal cur_len.
- Output handshake:
  - out_* are registered.
  - Held stable while out_valid && !out_ready.
  - Next symbol is presented the cycle after a handshake (one symbol per cycle at full throughput).
  - out_last=1 only on the final symbol of the final run.
- Histogram and count:
  - freq[out_sym] += 1 on each out handshake, saturating at 2^FREQ_W-1.
  - sym_count increments on each out handshake.
- Boundaries:
  - Runs span the LL/distance boundary; the input is one sequence.
  - If run_cnt reaches MAX_RUN, the next equal length forces a flush first (treated as different).
  - len_valid with len_ready=0 is held by the source; nothing is dropped.
  - Latency: first symbol appears no earlier than 1 cycle after the length that ends the run is accepted.

Test Plan:
- Eight 8s, last on the 8th.
  - Required symbols: 8; 16 extra 3 nbits 2; 8 (out_last).
  - freq[8]=2, freq[16]=1, sym_count=3, done pulses once.
- 140 zeros, last.
  - Required symbols: 18 extra 127 nbits 7; 0; 0 (out_last).
  - freq[18]=1, freq[0]=2.
- Input [0,0,0,0,0,5,5,5], last on the final 5.
  - Required symbols: 17 extra 2 nbits 3; 5; 5; 5.
  - len_ready is 0 while the 17 is flushed.
- Single length 3 with last.
  - Required: one symbol 3 with out_last.
  - done fires the cycle after the handshake; further len_valid is not accepted until start.
- 20 sevens, with out_ready held low 5 cycles after the first 16 is presented.
  - out_sym/out_extra are stable throughout the stall.
  - Symbol sequence: 7; 16/3; 16/3; 16/3; 7.
- Reset asserted mid-flush of the 140-zero case.
  - Next cycle: out_valid=0, len_ready=1, freq_data=0 for all addresses, sym_count=0.
